svc_axil_sram_if_rd: RTL and testbench

Read-channel bridge from an AXI-Lite subordinate port to the internal SRAM command/response interface. It converts AR beats into SRAM read commands, with the byte address converted to a word address. It returns SRAM read data as R beats with OKAY response. It sits between the AXI-Lite interconnect and the SRAM controller, alongside the matching write-side bridge.

---
 rtl/svc_axil_sram_if_rd_pkg.sv | 11 +
 rtl/svc_axil_sram_if_rd_cnt.sv | 30 +++
 rtl/svc_axil_sram_if_rd.sv | 80 ++++++++
 tb/tb_svc_axil_sram_if_rd.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/svc_axil_sram_if_rd_pkg.sv
// Shared AXI-Lite constants for the SRAM read bridge.
package svc_axil_sram_if_rd_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/svc_axil_sram_if_rd_cnt.sv
// Up/down counter of reads accepted but not yet answered; saturates at zero.
module svc_axil_sram_if_rd_cnt #(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_below_limit
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      r_count <= r_count + CW'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      // A response with nothing tracked (e.g. issued before reset) is ignored.
      r_count <= r_count - CW'(1);
    end
  end

  assign o_count       = r_count;
  assign o_below_limit = (r_count < CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/svc_axil_sram_if_rd.sv
// AXI-Lite read channel to SRAM command/response bridge; combinational paths,
// outstanding-read limit. Optional checks: `define SVC_AXIL_SRAM_IF_RD_ASSERT_EN.
module svc_axil_sram_if_rd
  import svc_axil_sram_if_rd_pkg::*;
#(
  parameter  int AXIL_ADDR_WIDTH = 20,
  parameter  int AXIL_DATA_WIDTH = 16,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int LSB             = $clog2(AXIL_DATA_WIDTH) - 3,
  localparam int SAW             = AXIL_ADDR_WIDTH - LSB
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,

  output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,

  output logic                       sram_rd_cmd_valid,
  input  logic                       sram_rd_cmd_ready,
  output logic [SAW-1:0]             sram_rd_cmd_addr,

  input  logic                       sram_resp_rd_valid,
  output logic                       sram_resp_rd_ready,
  input  logic [AXIL_DATA_WIDTH-1:0] sram_resp_rd_data
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic          w_can_issue;
  logic          w_below_limit;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic [CW-1:0] w_count;

  svc_axil_sram_if_rd_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_inc        (w_ar_hs),
    .i_dec        (w_r_hs),
    .o_count      (w_count),
    .o_below_limit(w_below_limit)
  );

  assign w_can_issue = !rst && w_below_limit;

  assign sram_rd_cmd_valid = s_axil_arvalid && w_can_issue;
  assign s_axil_arready    = sram_rd_cmd_ready && w_can_issue;
  assign sram_rd_cmd_addr  = s_axil_araddr[AXIL_ADDR_WIDTH-1:LSB];

  assign s_axil_rvalid      = sram_resp_rd_valid && !rst;
  assign s_axil_rdata       = sram_resp_rd_data;
  assign s_axil_rresp       = AXI_RESP_OKAY;
  assign sram_resp_rd_ready = s_axil_rready && !rst;

  assign w_ar_hs = s_axil_arvalid && s_axil_arready;
  assign w_r_hs  = s_axil_rvalid && s_axil_rready;

`ifdef SVC_AXIL_SRAM_IF_RD_ASSERT_EN
  a_ar_stable : assert property (@(posedge clk) disable iff (rst)
    (s_axil_arvalid && !s_axil_arready) |=> (s_axil_arvalid && $stable(s_axil_araddr)));

  a_r_tracked : assert property (@(posedge clk) disable iff (rst)
    w_r_hs |-> (w_count != '0));

  a_cnt_limit : assert property (@(posedge clk) disable iff (rst)
    w_count <= CW'(MAX_OUTSTANDING));
`else
  logic w_unused_count;
  assign w_unused_count = ^w_count;
`endif

endmodule

// File: tb/tb_svc_axil_sram_if_rd.sv
// Directed self-checking bench for svc_axil_sram_if_rd (default parameters).
module tb_svc_axil_sram_if_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [19:0] s_axil_araddr;
  logic [15:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic        sram_rd_cmd_valid;
  logic        sram_rd_cmd_ready;
  logic [18:0] sram_rd_cmd_addr;
  logic        sram_resp_rd_valid;
  logic        sram_resp_rd_ready;
  logic [15:0] sram_resp_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svc_axil_sram_if_rd #(
    .AXIL_ADDR_WIDTH(20),
    .AXIL_DATA_WIDTH(16),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axil_arvalid    (s_axil_arvalid),
    .s_axil_arready    (s_axil_arready),
    .s_axil_araddr     (s_axil_araddr),
    .s_axil_rdata      (s_axil_rdata),
    .s_axil_rresp      (s_axil_rresp),
    .s_axil_rvalid     (s_axil_rvalid),
    .s_axil_rready     (s_axil_rready),
    .sram_rd_cmd_valid (sram_rd_cmd_valid),
    .sram_rd_cmd_ready (sram_rd_cmd_ready),
    .sram_rd_cmd_addr  (sram_rd_cmd_addr),
    .sram_resp_rd_valid(sram_resp_rd_valid),
    .sram_resp_rd_ready(sram_resp_rd_ready),
    .sram_resp_rd_data (sram_resp_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axil_arvalid     = 1'b0;
    s_axil_araddr      = '0;
    s_axil_rready      = 1'b0;
    sram_rd_cmd_ready  = 1'b0;
    sram_resp_rd_valid = 1'b0;
    sram_resp_rd_data  = '0;
  endtask

  // Accept n reads back to back (each must see arready), then show the limit.
  task automatic fill_and_block(input string tag, input int n);
    s_axil_arvalid    = 1'b1;
    sram_rd_cmd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_axil_araddr = 20'(32'h100 + 2 * i);
      #1;
      chk({tag, "_accept_ready"}, 32'(s_axil_arready), 32'd1);
      tick();
    end
    #1;
    chk({tag, "_block_ready"}, 32'(s_axil_arready), 32'd0);
    chk({tag, "_block_valid"}, 32'(sram_rd_cmd_valid), 32'd0);
  endtask

  // One R handshake with no AR activity.
  task automatic one_response(input logic [15:0] data);
    s_axil_arvalid     = 1'b0;
    sram_resp_rd_valid = 1'b1;
    sram_resp_rd_data  = data;
    s_axil_rready      = 1'b1;
    #1;
    chk("resp_rvalid", 32'(s_axil_rvalid), 32'd1);
    chk("resp_rdata", 32'(s_axil_rdata), 32'(data));
    tick();
    sram_resp_rd_valid = 1'b0;
    s_axil_rready      = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    // Reset with every input asserted: all handshake outputs must stay low.
    s_axil_arvalid     = 1'b1;
    sram_rd_cmd_ready  = 1'b1;
    sram_resp_rd_valid = 1'b1;
    s_axil_rready      = 1'b1;
    tick();
    chk("rst_arready", 32'(s_axil_arready), 32'd0);
    chk("rst_cmd_valid", 32'(sram_rd_cmd_valid), 32'd0);
    chk("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    chk("rst_resp_ready", 32'(sram_resp_rd_ready), 32'd0);
    chk("rst_rresp", 32'(s_axil_rresp), 32'd0);
    tick();

    rst = 1'b0;
    idle_inputs();
    #1;
    chk("idle_cmd_valid", 32'(sram_rd_cmd_valid), 32'd0);
    chk("idle_rvalid", 32'(s_axil_rvalid), 32'd0);
    chk("idle_arready", 32'(s_axil_arready), 32'd0);

    // Command held while SRAM stalls.
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 20'hA000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_cmd_valid", 32'(sram_rd_cmd_valid), 32'd1);
      chk("stall_cmd_addr", 32'(sram_rd_cmd_addr), 32'h5000);
      chk("stall_arready", 32'(s_axil_arready), 32'd0);
      tick();
    end
    sram_rd_cmd_ready = 1'b1;
    #1;
    chk("ar_hs_arready", 32'(s_axil_arready), 32'd1);
    tick();
    s_axil_arvalid = 1'b0;
    #1;
    chk("post_hs_cmd_valid", 32'(sram_rd_cmd_valid), 32'd0);

    // Address conversion: unaligned and top-of-range.
    s_axil_araddr = 20'hA001;
    #1;
    chk("unaligned_addr", 32'(sram_rd_cmd_addr), 32'h5000);
    s_axil_araddr = 20'hFFFFF;
    #1;
    chk("top_addr", 32'(sram_rd_cmd_addr), 32'h7FFFF);
    sram_rd_cmd_ready = 1'b0;

    // Response held while master stalls.
    sram_resp_rd_valid = 1'b1;
    sram_resp_rd_data  = 16'hD000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rstall_rvalid", 32'(s_axil_rvalid), 32'd1);
      chk("rstall_rdata", 32'(s_axil_rdata), 32'hD000);
      chk("rstall_rresp", 32'(s_axil_rresp), 32'd0);
      chk("rstall_resp_ready", 32'(sram_resp_rd_ready), 32'd0);
      tick();
    end
    s_axil_rready = 1'b1;
    #1;
    chk("r_hs_resp_ready", 32'(sram_resp_rd_ready), 32'd1);
    tick();
    idle_inputs();

    // Count is 0: fill to the limit, then free one slot.
    fill_and_block("fill4", 4);
    sram_resp_rd_valid = 1'b1;
    sram_resp_rd_data  = 16'h1234;
    s_axil_rready      = 1'b1;
    #1;
    chk("full_r_beat_arready", 32'(s_axil_arready), 32'd0);
    tick();
    sram_resp_rd_valid = 1'b0;
    s_axil_rready      = 1'b0;
    #1;
    chk("fifth_accept_ready", 32'(s_axil_arready), 32'd1);
    chk("fifth_accept_valid", 32'(sram_rd_cmd_valid), 32'd1);
    tick();
    #1;
    chk("refull_block_ready", 32'(s_axil_arready), 32'd0);

    // Drain to 2, then AR and R handshakes in the same cycle.
    one_response(16'h0002);
    one_response(16'h0003);
    s_axil_arvalid     = 1'b1;
    sram_rd_cmd_ready  = 1'b1;
    sram_resp_rd_valid = 1'b1;
    s_axil_rready      = 1'b1;
    #1;
    chk("both_arready", 32'(s_axil_arready), 32'd1);
    chk("both_resp_ready", 32'(sram_resp_rd_ready), 32'd1);
    tick();
    sram_resp_rd_valid = 1'b0;
    s_axil_rready      = 1'b0;
    fill_and_block("after_both", 2);

    // Count 4 -> 3, then reset mid-flight.
    one_response(16'h0004);
    rst                = 1'b1;
    s_axil_arvalid     = 1'b1;
    sram_rd_cmd_ready  = 1'b1;
    sram_resp_rd_valid = 1'b1;
    s_axil_rready      = 1'b1;
    #1;
    chk("midrst_arready", 32'(s_axil_arready), 32'd0);
    chk("midrst_cmd_valid", 32'(sram_rd_cmd_valid), 32'd0);
    chk("midrst_rvalid", 32'(s_axil_rvalid), 32'd0);
    chk("midrst_resp_ready", 32'(sram_resp_rd_ready), 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();

    // Response with count 0 is forwarded and leaves the count at 0.
    one_response(16'hBEEF);
    fill_and_block("after_rst", 4);

    idle_inputs();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
